// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversampling tick generator, two-flop line
// synchroniser, start/data/parity/stop sequencer, small receive FIFO drained
// over valid/ready, and sticky parity/framing/overrun status flags.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          d_in,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] tick_cnt_reg;
    logic             tick;

    // Compare with >= so a baud_div shrunk below the running count wraps at
    // the next compare instead of running off to the top of the counter.
    assign tick = en && (tick_cnt_reg >= baud_div);

    // Tick counter: held at zero while disabled, wraps on every tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_reg <= '0;
        end else if (!en || tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Line synchroniser
    // ------------------------------------------------------------------
    logic sync1_reg;
    logic sync2_reg;
    logic s_in;

    assign s_in = sync2_reg;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= d_in;
            sync2_reg <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t     state_reg,   state_next;
    logic [3:0] s_cnt_reg,   s_cnt_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg,   shift_next;
    logic       par_bad_reg, par_bad_next;
    logic       armed_reg,   armed_next;
    logic       push_set;
    logic       perr_set;
    logic       ferr_set;

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            s_cnt_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_bad_reg <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            s_cnt_reg   <= s_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_bad_reg <= par_bad_next;
            armed_reg   <= armed_next;
        end
    end

    // Next-state logic: everything advances only on an oversample tick.
    always_comb begin
        state_next   = state_reg;
        s_cnt_next   = s_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_bad_next = par_bad_reg;
        armed_next   = armed_reg;
        push_set     = 1'b0;
        perr_set     = 1'b0;
        ferr_set     = 1'b0;

        if (!en) begin
            // Disabling drops any partial frame and requires a fresh idle
            // level before the next start bit is accepted.
            state_next = IDLE;
            s_cnt_next = '0;
            armed_next = 1'b0;
        end else if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (s_in) begin
                        armed_next = 1'b1;
                    end else if (armed_reg) begin
                        state_next = START;
                        s_cnt_next = '0;
                    end
                end
                START: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (s_cnt_reg == 4'd7) begin
                        if (s_in) begin
                            state_next = IDLE;
                        end else begin
                            state_next   = DATA;
                            s_cnt_next   = '0;
                            bit_cnt_next = '0;
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + 4'd1;
                    end
                end
                DATA: begin
                    s_cnt_next = s_cnt_reg + 4'd1;
                    if (s_cnt_reg == 4'd15) begin
                        shift_next   = {s_in, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_next = PARITY;
                        end
                    end
                end
                PARITY: begin
                    s_cnt_next = s_cnt_reg + 4'd1;
                    if (s_cnt_reg == 4'd15) begin
                        par_bad_next = (^shift_reg) ^ s_in;
                        state_next   = STOP;
                    end
                end
                STOP: begin
                    s_cnt_next = s_cnt_reg + 4'd1;
                    if (s_cnt_reg == 4'd15) begin
                        if (!s_in) begin
                            // Low stop bit: framing error, and stay disarmed
                            // so a held break does not spawn new frames.
                            ferr_set   = 1'b1;
                            armed_next = 1'b0;
                        end else if (par_bad_reg) begin
                            perr_set = 1'b1;
                        end else begin
                            push_set = 1'b1;
                        end
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Push register
    // ------------------------------------------------------------------
    logic       push_reg;
    logic [7:0] push_data_reg;

    // Validated bytes enter the FIFO one clock after the stop sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            push_reg      <= 1'b0;
            push_data_reg <= '0;
        end else begin
            push_reg <= push_set;
            if (push_set) begin
                push_data_reg <= shift_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic             rx_valid_reg;
    logic [7:0]       rx_data_reg, head_next;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             ovr_set;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop     = rx_valid_reg && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en   = push_reg && (!full || pop);
    assign ovr_set = push_reg && full && !pop;

    // Pointer/count bookkeeping and the next head byte (with write bypass
    // for the case where the incoming byte becomes the new head).
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = push_data_reg;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // FIFO storage array; contents need no reset since the pointers do.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data_reg;
        end
    end

    // FIFO control registers and registered head/valid outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rx_valid_reg <= (count_next != '0);
            rx_data_reg  <= head_next;
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign fifo_count = count_reg;

    // ------------------------------------------------------------------
    // Sticky status flags
    // ------------------------------------------------------------------
    logic parity_err_reg;
    logic frame_err_reg;
    logic overrun_reg;

    // Sticky flags: a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            parity_err_reg <= perr_set || (parity_err_reg && !err_clr);
            frame_err_reg  <= ferr_set || (frame_err_reg  && !err_clr);
            overrun_reg    <= ovr_set  || (overrun_reg    && !err_clr);
        end
    end

    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of frames with expected FIFO
// and flag state, plus directed sequences for glitch, break, coincident
// push/pop, enable abort and reset abort.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] baud_div;
    logic        d_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .baud_div   (baud_div),
        .d_in       (d_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bit time is 16 ticks of 4 clk (baud_div = 3).
    task automatic bit_time(input logic v);
        d_in = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(p);
        bit_time(s);
    endtask

    task automatic idle_bits(input int n);
        d_in = 1'b1;
        repeat (n * 64) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input int limit, output logic ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== lvl && n < limit);
        ok = (busy === lvl);
    endtask

    task automatic pop_one;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_data"},    rx_data,    0);
        check({tag, " rx_valid"},   rx_valid,   0);
        check({tag, " fifo_count"}, fifo_count, 0);
        check({tag, " busy"},       busy,       0);
        check({tag, " flags"},      {parity_err, frame_err, overrun}, 0);
    endtask

    initial begin
        logic ok1, ok2, saw;

        // data  par   stop  count head   perr  ferr  ovr
        vecs[0] = '{8'h01, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 2, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 2, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 3, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 4, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h7E, 1'b0, 1'b1, 4, 8'h01, 1'b0, 1'b0, 1'b1};

        reset    = 1'b0;
        en       = 1'b1;
        baud_div = 16'd3;
        d_in     = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        idle_bits(2);

        // Single byte then a one-clock pop.
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        $display("frame a5: valid=%0d data=%02h count=%0d", rx_valid, rx_data, fifo_count);
        check("single valid", rx_valid, 1);
        check("single data", rx_data, 8'hA5);
        check("single count", fifo_count, 1);
        check("single flags", {parity_err, frame_err, overrun}, 0);
        pop_one();
        check("single pop valid", rx_valid, 0);
        check("single pop count", fifo_count, 0);

        // Table-driven frames with the consumer stalled.
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            idle_bits(1);
            $display("vec %0d: data=%02h par=%0d stop=%0d -> count=%0d head=%02h pe=%0d fe=%0d ov=%0d",
                     i, vecs[i].data, vecs[i].par, vecs[i].stop, fifo_count, rx_data,
                     parity_err, frame_err, overrun);
            check($sformatf("vec%0d count", i), fifo_count, vecs[i].exp_count);
            check($sformatf("vec%0d valid", i), rx_valid, (vecs[i].exp_count != 0));
            if (vecs[i].exp_count != 0)
                check($sformatf("vec%0d head", i), rx_data, vecs[i].exp_head);
            check($sformatf("vec%0d perr", i), parity_err, vecs[i].exp_perr);
            check($sformatf("vec%0d ferr", i), frame_err, vecs[i].exp_ferr);
            check($sformatf("vec%0d ovr", i), overrun, vecs[i].exp_ovr);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            check($sformatf("vec%0d clr", i), {parity_err, frame_err, overrun}, 0);
        end

        // Drain in order.
        begin
            logic [7:0] exp_order [4];
            exp_order = '{8'h01, 8'hFF, 8'h80, 8'h00};
            for (int i = 0; i < 4; i++) begin
                $display("drain %0d: data=%02h", i, rx_data);
                check($sformatf("drain%0d data", i), rx_data, exp_order[i]);
                pop_one();
            end
        end
        check("drain count", fifo_count, 0);
        check("drain valid", rx_valid, 0);

        // Glitch: line low for 4 ticks only.
        d_in = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch busy high", busy, 1);
        repeat (4) @(negedge clk);
        d_in = 1'b1;
        repeat (60) @(negedge clk);
        $display("glitch: busy=%0d count=%0d", busy, fifo_count);
        check("glitch busy low", busy, 0);
        check("glitch count", fifo_count, 0);
        check("glitch flags", {parity_err, frame_err, overrun}, 0);

        // Fill the FIFO, then land a pop on the same cycle as the fifth push.
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i * 8'h11), 1'b0, 1'b1);
            idle_bits(1);
        end
        check("fill count", fifo_count, 4);
        fork
            send_frame(8'h55, 1'b0, 1'b1);
            begin
                wait_busy(1'b1, 200, ok1);
                wait_busy(1'b0, 1000, ok2);
                pop_one();
            end
        join
        idle_bits(1);
        $display("coincident push/pop: count=%0d head=%02h ovr=%0d", fifo_count, rx_data, overrun);
        check("coinc busy seen", ok1, 1);
        check("coinc busy end", ok2, 1);
        check("coinc count", fifo_count, 4);
        check("coinc overrun", overrun, 0);
        check("coinc head", rx_data, 8'h22);
        rx_ready = 1'b1;
        repeat (8) @(negedge clk);
        rx_ready = 1'b0;
        check("coinc drain", fifo_count, 0);

        // Framing error followed by a held break.
        send_frame(8'h3C, 1'b0, 1'b0);
        saw = 1'b0;
        repeat (40 * 64) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        $display("break: ferr=%0d saw_busy=%0d count=%0d", frame_err, saw, fifo_count);
        check("break ferr", frame_err, 1);
        check("break no frame", saw, 0);
        check("break count", fifo_count, 0);
        idle_bits(2);
        send_frame(8'h55, 1'b0, 1'b1);
        idle_bits(1);
        $display("after break: data=%02h count=%0d", rx_data, fifo_count);
        check("post-break data", rx_data, 8'h55);
        check("post-break count", fifo_count, 1);
        check("post-break ferr sticky", frame_err, 1);

        // Drop enable during DATA.
        d_in = 1'b0;
        repeat (3 * 64) @(negedge clk);
        check("abort busy before", busy, 1);
        en = 1'b0;
        @(negedge clk);
        $display("en abort: busy=%0d count=%0d", busy, fifo_count);
        check("abort busy after", busy, 0);
        check("abort count", fifo_count, 1);
        check("abort head", rx_data, 8'h55);
        check("abort ferr kept", frame_err, 1);
        d_in = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b1;
        idle_bits(2);
        check("abort no restart", busy, 0);

        // Reset mid-frame.
        d_in = 1'b0;
        repeat (2 * 64) @(negedge clk);
        check("reset busy before", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        $display("mid-frame reset: busy=%0d count=%0d valid=%0d", busy, fifo_count, rx_valid);
        check_reset_outputs("midreset");
        reset = 1'b1;
        d_in = 1'b1;
        idle_bits(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
